md5_pad_ctrl: RTL and testbench

MD5_PAD_CTRL -- requirements
Module: md5_pad_ctrl

---
 rtl/md5_pkg.sv | 21 ++
 rtl/md5_pad_buf.sv | 43 ++++
 rtl/md5_pad_ctrl.sv | 173 +++++++++++++++++
 tb/tb_md5_pad_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 single-block padding controller.
package md5_pkg;

    localparam int MAX_MSG_BYTES = 55;
    localparam int BLOCK_WORDS   = 16;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PAD,
        WAIT_RDY,
        SEND,
        WAIT_DONE,
        RESULT
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/md5_pad_buf.sv
// 16x32 message block buffer: little-endian byte packing, MD5 padding and word read port.
module md5_pad_buf
    import md5_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [5:0]  wr_idx,
    input  logic [7:0]  wr_byte,
    input  logic        pad_en,
    input  logic [5:0]  len,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_word
);

    logic [31:0] mem [BLOCK_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
        end else if (pad_en) begin
            // Bytes before len keep the message; words 14/15 carry the bit length.
            for (int w = 0; w < 14; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (6'(4 * w + b) == len)
                        mem[w][8*b +: 8] <= 8'h80;
                    else if (6'(4 * w + b) > len)
                        mem[w][8*b +: 8] <= 8'h00;
                end
            end
            mem[14] <= {23'd0, len, 3'd0};
            mem[15] <= '0;
        end else if (wr_en) begin
            mem[wr_idx[5:2]][{wr_idx[1:0], 3'b000} +: 8] <= wr_byte;
        end
    end

    assign rd_word = mem[rd_idx];

endmodule

// File: rtl/md5_pad_ctrl.sv
// MD5 single-block padding controller: collects bytes, pads, feeds the core, captures the digest.
// Define MD5_DIGEST_BYTESWAP_EN to present the digest as the canonical MSB-first byte stream.
//
// state     | meaning
// IDLE      | empty buffer, waiting for the first byte
// COLLECT   | accepting bytes (also discarding after an overflow)
// PAD       | one cycle: 0x80 marker, zero fill, length word
// WAIT_RDY  | block ready, waiting for core_rdy
// SEND      | 16 word strobes to the core
// WAIT_DONE | waiting for core_done with timeout
// RESULT    | digest held until the consumer accepts it
module md5_pad_ctrl
    import md5_pkg::*;
#(
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         core_rdy,
    output logic         core_write_en,
    output logic [31:0]  core_msg,
    input  logic [31:0]  core_a,
    input  logic [31:0]  core_b,
    input  logic [31:0]  core_c,
    input  logic [31:0]  core_d,
    input  logic         core_done,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [127:0] digest,
    output logic         err
);

    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    state_t          state, state_next;
    logic [5:0]      cnt, cnt_next;
    logic            ovf, ovf_next;
    logic [3:0]      widx, widx_next;
    logic [TW-1:0]   timer, timer_next;
    logic [127:0]    dig_raw;
    logic            cap, err_next, in_ready_next;
    logic            buf_clr, buf_wr, pad_en;
    logic            accept;
    logic [31:0]     rd_word;

    assign accept = in_valid && in_ready;

    md5_pad_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (cnt),
        .wr_byte (in_data),
        .pad_en  (pad_en),
        .len     (cnt),
        .rd_idx  (widx),
        .rd_word (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ovf      <= 1'b0;
            widx     <= '0;
            timer    <= '0;
            dig_raw  <= '0;
            err      <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ovf      <= ovf_next;
            widx     <= widx_next;
            timer    <= timer_next;
            err      <= err_next;
            in_ready <= in_ready_next;
            if (cap) dig_raw <= {core_a, core_b, core_c, core_d};
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ovf_next   = ovf;
        widx_next  = widx;
        timer_next = timer;
        err_next   = 1'b0;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;
        pad_en     = 1'b0;
        cap        = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (ovf) begin
                        if (in_last) begin
                            state_next = IDLE;
                            ovf_next   = 1'b0;
                            cnt_next   = '0;
                            buf_clr    = 1'b1;
                        end
                    end else if (cnt == 6'(MAX_MSG_BYTES)) begin
                        // Overflowing byte: flag once, then drop everything up to in_last.
                        err_next   = 1'b1;
                        buf_clr    = 1'b1;
                        cnt_next   = '0;
                        ovf_next   = !in_last;
                        state_next = in_last ? IDLE : COLLECT;
                    end else begin
                        buf_wr     = 1'b1;
                        cnt_next   = cnt + 6'd1;
                        state_next = in_last ? PAD : COLLECT;
                    end
                end
            end
            PAD: begin
                pad_en     = 1'b1;
                state_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                widx_next = '0;
                if (core_rdy) state_next = SEND;
            end
            SEND: begin
                widx_next = widx + 4'd1;
                if (widx == 4'(BLOCK_WORDS - 1)) begin
                    state_next = WAIT_DONE;
                    timer_next = TW'(DONE_TIMEOUT);
                end
            end
            WAIT_DONE: begin
                if (core_done) begin
                    cap        = 1'b1;
                    state_next = RESULT;
                end else if (timer <= TW'(1)) begin
                    err_next   = 1'b1;
                    buf_clr    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            RESULT: begin
                if (dig_ready) begin
                    buf_clr    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        in_ready_next = (state_next == IDLE) || (state_next == COLLECT);
    end

    assign core_write_en = (state == SEND);
    assign core_msg      = core_write_en ? rd_word : 32'h0;
    assign dig_valid     = (state == RESULT);

`ifdef MD5_DIGEST_BYTESWAP_EN
    assign digest = {bswap32(dig_raw[127:96]), bswap32(dig_raw[95:64]),
                     bswap32(dig_raw[63:32]),  bswap32(dig_raw[31:0])};
`else
    assign digest = dig_raw;
`endif

endmodule

// File: tb/tb_md5_pad_ctrl.sv
// Self-checking bench for md5_pad_ctrl: word scoreboard, table of block-word checks, corner sequences.
module tb_md5_pad_ctrl;

    logic         clk, rst_n;
    logic         in_valid, in_ready, in_last;
    logic [7:0]   in_data;
    logic         core_rdy, core_write_en, core_done;
    logic [31:0]  core_msg, core_a, core_b, core_c, core_d;
    logic         dig_valid, dig_ready, err;
    logic [127:0] digest;

    md5_pad_ctrl #(.DONE_TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .core_rdy(core_rdy), .core_write_en(core_write_en), .core_msg(core_msg),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .core_done(core_done), .dig_valid(dig_valid), .dig_ready(dig_ready),
        .digest(digest), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cap[16];
    int          wr_count = 0;
    int          err_count = 0;
    int          err_at = -1;
    int          accepted = 0;
    logic [7:0]  msg[64];

    typedef struct {
        int          msg_id;
        int          word;
        logic [31:0] exp;
    } wchk_t;
    wchk_t tbl[9];

`ifdef MD5_DIGEST_BYTESWAP_EN
    localparam logic [127:0] HELLO_DIG = 128'h5d41402abc4b2a76b9719d911017c592;
    localparam logic [127:0] ABC_DIG   = 128'h900150983cd24fb0d6963f7d28e17f72;
`else
    localparam logic [127:0] HELLO_DIG = 128'h2a40415d762a4bbc919d71b992c51710;
    localparam logic [127:0] ABC_DIG   = 128'h98500190b04fd23c7d3f96d6727fe128;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every core word strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (core_write_en) begin
                    if (wr_count < 16) cap[wr_count] = core_msg;
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_write: got %h expected no strobe", core_msg);
                    end else begin
                        check("core_msg", core_msg, exp_q.pop_front());
                    end
                    wr_count++;
                end else begin
                    check("core_msg_idle_zero", core_msg, 0);
                end
                if (err) begin
                    err_count++;
                    err_at = accepted;
                end
            end
        end
    end

    task automatic set_text(input string s);
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
    endtask

    task automatic push_model(input int len);
        logic [31:0] w[16];
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        for (int n = 0; n < len; n++) w[n/4][8*(n%4) +: 8] = msg[n];
        w[len/4][8*(len%4) +: 8] = 8'h80;
        w[14] = 32'(len * 8);
        for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
    endtask

    task automatic drive_bytes(input int len);
        int t;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = msg[i]; in_last = (i == len - 1);
            check("in_ready_on_offer", in_ready, 1);
            t = 0;
            while (!in_ready && t < 200) begin @(negedge clk); t++; end
            @(posedge clk);
            accepted++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_count < n && t < 200) begin @(negedge clk); #1; t++; end
        check("write_count_reached", (wr_count >= n), 1);
    endtask

    task automatic finish_core(input logic [127:0] raw, input logic [127:0] exp_dig);
        int t = 0;
        {core_a, core_b, core_c, core_d} = raw;
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        while (!dig_valid && t < 50) begin @(negedge clk); t++; end
        check("dig_valid_rise", dig_valid, 1);
        check("digest", digest, exp_dig);
        core_a = 32'hdead0001; core_b = 32'hdead0002;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("digest_stable", digest, exp_dig);
        end
        check("dig_valid_held", dig_valid, 1);
        dig_ready = 1'b1;
        @(negedge clk); dig_ready = 1'b0;
        check("dig_valid_after_ack", dig_valid, 0);
        check("in_ready_after_ack", in_ready, 1);
    endtask

    task automatic check_table(input int id);
        for (int i = 0; i < 9; i++)
            if (tbl[i].msg_id == id)
                check($sformatf("block_word%0d_msg%0d", tbl[i].word, id), cap[tbl[i].word], tbl[i].exp);
    endtask

    task automatic run_msg(input int id, input int len, input logic [127:0] raw, input logic [127:0] exp_dig);
        wr_count = 0;
        push_model(len);
        drive_bytes(len);
        wait_writes(16);
        finish_core(raw, exp_dig);
        check("write_en_cycles", wr_count, 16);
        check("scoreboard_empty", exp_q.size(), 0);
        check_table(id);
    endtask

    initial begin
        int t, e0;
        tbl[0] = '{0, 0,  32'h6C6C6568};
        tbl[1] = '{0, 1,  32'h0000806F};
        tbl[2] = '{0, 14, 32'h00000028};
        tbl[3] = '{0, 15, 32'h00000000};
        tbl[4] = '{1, 0,  32'h80636261};
        tbl[5] = '{1, 14, 32'h00000018};
        tbl[6] = '{2, 12, 32'h61616161};
        tbl[7] = '{2, 13, 32'h80616161};
        tbl[8] = '{2, 14, 32'h000001B8};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0;
        core_rdy = 1'b1; core_done = 1'b0; dig_ready = 1'b0;
        core_a = '0; core_b = '0; core_c = '0; core_d = '0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_write_en", core_write_en, 0);
        check("rst_dig_valid", dig_valid, 0);
        check("rst_err", err, 0);
        check("rst_digest", digest, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);

        // core_done outside WAIT_DONE must be ignored
        core_a = 32'h11111111;
        core_done = 1'b1; @(negedge clk); core_done = 1'b0; @(negedge clk);
        check("spurious_done_idle", dig_valid, 0);
        check("spurious_done_digest", digest, 0);

        set_text("hello");
        run_msg(0, 5, 128'h2a40415d762a4bbc919d71b992c51710, HELLO_DIG);

        // 60-byte message: overflow at byte 56, no core activity
        for (int i = 0; i < 60; i++) msg[i] = 8'h62;
        wr_count = 0; err_count = 0; accepted = 0;
        drive_bytes(60);
        repeat (4) @(negedge clk);
        check("ovf_err_pulses", err_count, 1);
        check("ovf_err_at_byte", err_at, 56);
        check("ovf_no_writes", wr_count, 0);
        check("ovf_in_ready_idle", in_ready, 1);
        check("ovf_dig_valid", dig_valid, 0);

        // abc with the core initially not ready
        set_text("abc");
        core_rdy = 1'b0;
        wr_count = 0;
        push_model(3);
        drive_bytes(3);
        repeat (5) @(negedge clk);
        core_done = 1'b1; @(negedge clk); core_done = 1'b0;
        repeat (2) @(negedge clk);
        check("wait_rdy_no_writes", wr_count, 0);
        check("wait_rdy_no_digest", dig_valid, 0);
        check("wait_rdy_in_ready", in_ready, 0);
        core_rdy = 1'b1;
        wait_writes(16);
        finish_core(128'h98500190b04fd23c7d3f96d6727fe128, ABC_DIG);
        check("abc_write_en_cycles", wr_count, 16);
        check_table(1);

        for (int i = 0; i < 55; i++) msg[i] = 8'h61;
        run_msg(2, 55, 128'h0123456789abcdef0011223344556677,
`ifdef MD5_DIGEST_BYTESWAP_EN
                128'h67452301efcdab893322110077665544
`else
                128'h0123456789abcdef0011223344556677
`endif
        );

        // core_done withheld: timeout error
        set_text("abc");
        wr_count = 0; err_count = 0;
        push_model(3);
        drive_bytes(3);
        wait_writes(16);
        e0 = err_count; t = 0;
        while (err_count == e0 && t < 1200) begin @(negedge clk); #1; t++; end
        check("timeout_err_seen", (err_count == e0 + 1), 1);
        check("timeout_latency", (t >= 1024 && t <= 1026), 1);
        repeat (3) @(negedge clk);
        check("timeout_single_pulse", err_count, e0 + 1);
        check("timeout_in_ready", in_ready, 1);
        check("timeout_dig_valid", dig_valid, 0);

        // reset while word 7 is on the bus
        wr_count = 0;
        push_model(3);
        drive_bytes(3);
        t = 0;
        while (wr_count < 8 && t < 200) begin @(negedge clk); #1; t++; end
        check("midsend_reached_word7", wr_count, 8);
        #1 rst_n = 1'b0;
        #1;
        check("midsend_write_en", core_write_en, 0);
        check("midsend_core_msg", core_msg, 0);
        check("midsend_in_ready", in_ready, 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("midsend_in_ready_release", in_ready, 1);

        set_text("hello");
        run_msg(0, 5, 128'h2a40415d762a4bbc919d71b992c51710, HELLO_DIG);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
